// File: rtl/spi_cfg_pkg.sv
// Shared types and constants for the SPI configuration master: FSM states,
// frame layout and the peripheral register map.
package spi_cfg_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_HIGH,
      ST_LOW,
      ST_GAP
   } state_e;

   localparam int   FRAME_BITS = 16;
   localparam logic WRITE_BIT  = 1'b1;

   localparam logic [6:0] ADDR_EN_OUT_7_0  = 7'h00;
   localparam logic [6:0] ADDR_EN_OUT_15_8 = 7'h01;
   localparam logic [6:0] ADDR_PWM_CTRL    = 7'h02;
   localparam logic [6:0] ADDR_PWM_PERIOD  = 7'h03;
   localparam logic [6:0] ADDR_PWM_DUTY    = 7'h04;

   // Frame layout on the wire, MSB first: {write flag, 7-bit address, 8-bit data}.
   function automatic logic [FRAME_BITS-1:0] make_frame(input logic [6:0] addr,
                                                        input logic [7:0] data);
      return {WRITE_BIT, addr, data};
   endfunction

endpackage

// File: rtl/spi_cfg_master_if.sv
// Request bus between the two configuration writers and the SPI master.
interface spi_cfg_master_if;

   logic [1:0] req_valid;
   logic [1:0] req_ready;
   logic [6:0] req0_addr;
   logic [6:0] req1_addr;
   logic [7:0] req0_data;
   logic [7:0] req1_data;

   modport master (
      output req_valid, req0_addr, req1_addr, req0_data, req1_data,
      input  req_ready
   );

   modport slave (
      input  req_valid, req0_addr, req1_addr, req0_data, req1_data,
      output req_ready
   );

endinterface

// File: rtl/spi_cfg_rr_arb.sv
// Two-way round-robin arbiter: on a tie the requester not served last wins;
// priority moves only when the master strobes advance_i.
module spi_cfg_rr_arb (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] valid_i,
   input  logic       advance_i,
   output logic [1:0] grant_o
);

   logic last_q;

   always_comb begin
      grant_o = 2'b00;
      case (valid_i)
         2'b01:   grant_o = 2'b01;
         2'b10:   grant_o = 2'b10;
         2'b11:   grant_o = last_q ? 2'b01 : 2'b10;
         default: grant_o = 2'b00;
      endcase
   end

   // Reset value 1 makes requester 0 the winner of the first tie.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_q <= 1'b1;
      end else if (advance_i && (|grant_o)) begin
         last_q <= grant_o[1];
      end
   end

endmodule

// File: rtl/spi_cfg_master.sv
// SPI mode-0 write-only configuration master: accepts writes from two
// round-robin requesters and shifts each out as one 16-bit frame.
module spi_cfg_master
   import spi_cfg_pkg::*;
#(
   parameter int HALF_PERIOD = 4,
   parameter int CS_SETUP    = 4,
   parameter int CS_GAP      = 8
) (
   input  logic            clk,
   input  logic            rst_n,
   spi_cfg_master_if.slave req,
   output logic            grant_id,
   output logic            busy,
   output logic            done,
   output logic            nCS,
   output logic            SCLK,
   output logic            COPI
);

   localparam logic [7:0] SETUP_LD = 8'(CS_SETUP - 1);
   localparam logic [7:0] HALF_LD  = 8'(HALF_PERIOD - 1);
   localparam logic [7:0] GAP_LD   = 8'(CS_GAP - 1);
   localparam logic [3:0] BIT_TOP  = 4'(FRAME_BITS - 1);

   state_e                state_q;
   logic [7:0]            phase_q;
   logic [3:0]            bit_q;
   logic [FRAME_BITS-1:0] frame_q;
   logic [1:0]            ready_q;
   logic                  rdy_en_q;
   logic                  grant_q;
   logic                  busy_q;
   logic                  done_q;
   logic                  ncs_q;
   logic                  sclk_q;
   logic                  copi_q;

   logic                  accept;
   logic                  phase_end;
   logic [1:0]            arb_valid;
   logic [1:0]            arb_grant;
   logic [FRAME_BITS-1:0] frame_in;

   assign accept    = (state_q == ST_IDLE) && (|(req.req_valid & ready_q));
   assign phase_end = (phase_q == 8'd0);
   // In the accept cycle the arbiter sees only the winner, so its priority follows the frame really started.
   assign arb_valid = accept ? ready_q : req.req_valid;
   assign frame_in  = ready_q[1] ? make_frame(req.req1_addr, req.req1_data)
                                 : make_frame(req.req0_addr, req.req0_data);

   spi_cfg_rr_arb u_arb (
      .clk       (clk),
      .rst_n     (rst_n),
      .valid_i   (arb_valid),
      .advance_i (accept),
      .grant_o   (arb_grant)
   );

   // NOTE: every register, the frame shadow included, is cleared by the async reset so an abandoned frame leaves no state behind.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         phase_q  <= 8'd0;
         bit_q    <= 4'd0;
         frame_q  <= '0;
         ready_q  <= 2'b00;
         rdy_en_q <= 1'b0;
         grant_q  <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         ncs_q    <= 1'b1;
         sclk_q   <= 1'b0;
         copi_q   <= 1'b0;
      end else begin
         // NOTE: defaults first, then per-state overrides; with <= the last assignment in the block wins.
         rdy_en_q <= 1'b1;
         done_q   <= 1'b0;
         ready_q  <= 2'b00;
         if (!phase_end) phase_q <= phase_q - 8'd1;

         case (state_q)
            ST_IDLE: begin
               if (accept) begin
                  state_q <= ST_SETUP;
                  phase_q <= SETUP_LD;
                  bit_q   <= BIT_TOP;
                  frame_q <= frame_in;
                  grant_q <= ready_q[1];
                  busy_q  <= 1'b1;
                  ncs_q   <= 1'b0;
                  sclk_q  <= 1'b0;
                  copi_q  <= frame_in[FRAME_BITS-1];
               end else if (rdy_en_q) begin
                  ready_q <= arb_grant;
               end
            end
            ST_SETUP: begin
               if (phase_end) begin
                  state_q <= ST_HIGH;
                  phase_q <= HALF_LD;
                  sclk_q  <= 1'b1;
               end
            end
            ST_HIGH: begin
               if (phase_end) begin
                  state_q <= ST_LOW;
                  phase_q <= HALF_LD;
                  sclk_q  <= 1'b0;
                  if (bit_q != 4'd0) copi_q <= frame_q[bit_q - 4'd1];
               end
            end
            ST_LOW: begin
               if (phase_end) begin
                  if (bit_q == 4'd0) begin
                     state_q <= ST_GAP;
                     phase_q <= GAP_LD;
                     ncs_q   <= 1'b1;
                     copi_q  <= 1'b0;
                     done_q  <= 1'b1;
                  end else begin
                     state_q <= ST_HIGH;
                     phase_q <= HALF_LD;
                     bit_q   <= bit_q - 4'd1;
                     sclk_q  <= 1'b1;
                  end
               end
            end
            ST_GAP: begin
               if (phase_end) begin
                  state_q <= ST_IDLE;
                  busy_q  <= 1'b0;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign req.req_ready = ready_q;
   assign grant_id      = grant_q;
   assign busy          = busy_q;
   assign done          = done_q;
   assign nCS           = ncs_q;
   assign SCLK          = sclk_q;
   assign COPI          = copi_q;

endmodule

// File: tb/tb_spi_cfg_master.sv
// Directed bench for spi_cfg_master: a bus monitor decodes SPI frames into a
// register-peripheral model, and hand-computed frames and timing are compared.
module tb_spi_cfg_master;
   import spi_cfg_pkg::*;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic grant_id, busy, done, nCS, SCLK, COPI;
   int   cyc   = 0;
   int   n_cmp = 0;
   int   n_bad = 0;

   spi_cfg_master_if bus ();

   spi_cfg_master #(.HALF_PERIOD(4), .CS_SETUP(4), .CS_GAP(8)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .req      (bus.slave),
      .grant_id (grant_id),
      .busy     (busy),
      .done     (done),
      .nCS      (nCS),
      .SCLK     (SCLK),
      .COPI     (COPI)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Bus monitor plus register-peripheral model, sampled mid-cycle.
   logic [15:0] shreg     = '0;
   int          nbits     = 0;
   int          nlow      = 0;
   int          done_cnt  = 0;
   logic        ncs_prev  = 1'b1;
   logic        sclk_prev = 1'b0;
   bit          periph_clr = 1'b0;
   logic [7:0]  regs [0:4];
   logic [15:0] frames[$];
   int          fbits[$];
   int          flen[$];

   always @(negedge clk) begin
      if (periph_clr) for (int i = 0; i < 5; i++) regs[i] = 8'h00;
      if (!nCS) begin
         nlow++;
         if (SCLK && !sclk_prev) begin
            shreg = {shreg[14:0], COPI};
            nbits++;
         end
      end else if (!ncs_prev) begin
         frames.push_back(shreg);
         fbits.push_back(nbits);
         flen.push_back(nlow);
         if (nbits == 16 && shreg[15] && shreg[14:8] <= 7'd4) regs[shreg[10:8]] = shreg[7:0];
         nlow  = 0;
         nbits = 0;
         shreg = '0;
      end
      if (done) done_cnt++;
      ncs_prev  = nCS;
      sclk_prev = SCLK;
   end

   logic acc_id[$];
   logic gid[$];
   int   acc_cyc[$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic serve(input logic [1:0] want, input int n);
      int   got  = 0;
      logic pend = 1'b0;
      @(posedge clk); #1;
      bus.req_valid = want;
      for (int c = 0; c < 3000 && got < n; c++) begin
         @(negedge clk);
         if (pend) begin
            gid.push_back(grant_id);
            pend = 1'b0;
         end
         if (|(bus.req_valid & bus.req_ready)) begin
            acc_id.push_back(bus.req_ready[1]);
            acc_cyc.push_back(cyc);
            got++;
            pend = 1'b1;
         end
      end
      @(posedge clk); #1;
      bus.req_valid = 2'b00;
      if (pend) begin
         @(negedge clk);
         gid.push_back(grant_id);
      end
      check("accept_count", got, n);
   endtask

   task automatic wait_frames(input int n);
      int c = 0;
      while (frames.size() < n && c < 3000) begin
         @(negedge clk);
         c++;
      end
      repeat (12) @(negedge clk);
      if (frames.size() < n) check("frame_timeout", frames.size(), n);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int bf, bd, ba;
      logic [15:0] exp_f[$];
      logic [7:0]  sb [0:4];
      logic [6:0]  a;
      logic [7:0]  d;

      bus.req_valid = 2'b00;
      bus.req0_addr = '0;  bus.req0_data = '0;
      bus.req1_addr = '0;  bus.req1_data = '0;

      // Reset state and the ready-after-reset latency.
      repeat (3) @(negedge clk);
      check("rst_ncs", nCS, 1);
      check("rst_sclk", SCLK, 0);
      check("rst_copi", COPI, 0);
      check("rst_ready", bus.req_ready, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_gid", grant_id, 0);

      bus.req0_addr = ADDR_PWM_DUTY;
      bus.req0_data = 8'hA5;
      bus.req_valid = 2'b01;
      bf = frames.size();
      bd = done_cnt;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("ready_edge1", bus.req_ready, 2'b00);
      @(negedge clk);
      check("ready_edge2", bus.req_ready, 2'b01);
      @(posedge clk); #1;
      bus.req_valid = 2'b00;
      repeat (20) @(negedge clk);
      check("mid_busy", busy, 1);
      check("mid_ready", bus.req_ready, 0);
      check("mid_ncs", nCS, 0);
      wait_frames(bf + 1);
      check("f1_data", frames[bf], 16'h84A5);
      check("f1_bits", fbits[bf], 16);
      check("f1_ncs_low", flen[bf], 132);
      check("f1_done", done_cnt - bd, 1);
      check("f1_busy_end", busy, 0);
      check("f1_gid", grant_id, 0);

      // Simultaneous requests after reset: requester 0 first.
      do_reset();
      bus.req0_addr = 7'h01; bus.req0_data = 8'h5A;
      bus.req1_addr = 7'h02; bus.req1_data = 8'hC3;
      bf = frames.size(); bd = done_cnt; ba = acc_id.size();
      serve(2'b11, 2);
      wait_frames(bf + 2);
      check("tie_first", acc_id[ba], 0);
      check("tie_second", acc_id[ba+1], 1);
      check("tie_gid0", gid[ba], 0);
      check("tie_gid1", gid[ba+1], 1);
      check("tie_f0", frames[bf], 16'h815A);
      check("tie_f1", frames[bf+1], 16'h82C3);
      check("tie_done", done_cnt - bd, 2);

      // Both held for four frames: strict alternation at minimum spacing.
      bus.req0_addr = 7'h03; bus.req0_data = 8'h77;
      bus.req1_addr = 7'h04; bus.req1_data = 8'h99;
      bf = frames.size(); ba = acc_id.size();
      serve(2'b11, 4);
      wait_frames(bf + 4);
      for (int k = 0; k < 4; k++) begin
         check($sformatf("rr_id%0d", k), acc_id[ba+k], k % 2);
         check($sformatf("rr_gid%0d", k), gid[ba+k], k % 2);
         check($sformatf("rr_frame%0d", k), frames[bf+k], (k % 2) ? 16'h8499 : 16'h8377);
      end
      for (int k = 1; k < 4; k++)
         check($sformatf("rr_space%0d", k), acc_cyc[ba+k] - acc_cyc[ba+k-1], 142);

      // Reset during bit 7 abandons the frame; a later request is clean.
      bus.req0_addr = 7'h02; bus.req0_data = 8'h55;
      bf = frames.size(); bd = done_cnt;
      serve(2'b01, 1);
      for (int c = 0; c < 400 && nbits < 9; c++) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("abort_ncs", nCS, 1);
      check("abort_busy", busy, 0);
      repeat (4) @(negedge clk);
      check("abort_bits", fbits[bf], 9);
      rst_n = 1'b1;
      repeat (30) @(negedge clk);
      check("abort_done", done_cnt - bd, 0);
      check("abort_no_retry", frames.size(), bf + 1);
      bus.req1_addr = 7'h01; bus.req1_data = 8'h3C;
      serve(2'b10, 1);
      wait_frames(bf + 2);
      check("post_abort_frame", frames[bf+1], 16'h813C);
      check("post_abort_bits", fbits[bf+1], 16);
      check("post_abort_low", flen[bf+1], 132);
      check("post_abort_gid", grant_id, 1);

      // Data changed one cycle after acceptance must not reach the wire.
      bus.req0_addr = 7'h03; bus.req0_data = 8'h11;
      bf = frames.size();
      serve(2'b01, 1);
      bus.req0_data = 8'hEE;
      bus.req0_addr = 7'h7F;
      wait_frames(bf + 1);
      check("shadow_frame", frames[bf], 16'h8311);

      // Random writes through the peripheral model against a scoreboard.
      @(posedge clk); #1 periph_clr = 1'b1;
      @(posedge clk); #1 periph_clr = 1'b0;
      for (int i = 0; i < 5; i++) sb[i] = 8'h00;
      bf = frames.size();
      for (int k = 0; k < 12; k++) begin
         a = (k % 3 == 2) ? 7'($urandom_range(5, 127)) : 7'($urandom_range(0, 4));
         d = 8'($urandom);
         if (k % 2) begin
            bus.req1_addr = a; bus.req1_data = d;
         end else begin
            bus.req0_addr = a; bus.req0_data = d;
         end
         exp_f.push_back({1'b1, a, d});
         if (a <= 7'd4) sb[a[2:0]] = d;
         serve((k % 2) ? 2'b10 : 2'b01, 1);
      end
      wait_frames(bf + 12);
      for (int k = 0; k < 12; k++) check($sformatf("sb_frame%0d", k), frames[bf+k], exp_f[k]);
      for (int i = 0; i < 5; i++) check($sformatf("sb_reg%0d", i), regs[i], sb[i]);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
